// File: rtl/seg7_display_arbiter_if.sv
// seg7_display_arbiter_if: request/value bundle into the display arbiter
// and owner/value bundle out of it. master = producers, slave = arbiter.
interface seg7_display_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int VAL_W   = 14
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*VAL_W-1:0] req_value;
  logic [NUM_REQ-1:0]       grant;
  logic [2:0]               owner_id;
  logic                     busy;
  logic [VAL_W-1:0]         disp_value;
  logic                     overflow;

  modport master (
    output req,
    output req_value,
    input  grant,
    input  owner_id,
    input  busy,
    input  disp_value,
    input  overflow
  );

  modport slave (
    input  req,
    input  req_value,
    output grant,
    output owner_id,
    output busy,
    output disp_value,
    output overflow
  );
endinterface

// File: rtl/seg7_display_arbiter.sv
// seg7_display_arbiter: round-robin owner of the shared 4-digit display
// with a minimum dwell per grant and a registered value clamped to 9999.
// Ports: clk; rst_n (sync, active low); bus (slave): req, req_value in;
//  grant (one-hot), owner_id, busy, disp_value, overflow out.
module seg7_display_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int VAL_W      = 14,
  parameter int MIN_HOLD   = 50000000,
  parameter int IDLE_VALUE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg7_display_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MIN_HOLD + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MIN_HOLD - 1);
  localparam logic [2:0] PTR_RST = 3'(NUM_REQ - 1);
  localparam logic [VAL_W-1:0] IDLE_V = VAL_W'(IDLE_VALUE);
  localparam logic [VAL_W-1:0] MAX_V = VAL_W'(9999);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_OPEN
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         own_q, own_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [VAL_W-1:0]   disp_q, disp_d;
  logic               ovf_q, ovf_d;

  logic [3:0]         pick;
  logic               own_req;
  logic [VAL_W-1:0]   own_val;

  // Returns {found, index}. Distance is measured from ptr+1, so the
  // pointer (last owner) itself has the lowest priority.
  function automatic logic [3:0] rr_pick(
    input logic [NUM_REQ-1:0] r,
    input logic [2:0]         p
  );
    logic [3:0] res;
    int d;
    int best;
    res  = '0;
    best = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + 2*NUM_REQ - int'(p) - 1) % NUM_REQ;
      if (r[i] && d < best) begin
        best = d;
        res  = {1'b1, 3'(i)};
      end
    end
    return res;
  endfunction

  function automatic logic over(input logic [VAL_W-1:0] v);
    return 32'(v) > 32'd9999;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    pick    = rr_pick(bus.req, ptr_q);
    unique case (state_q)
      S_IDLE: begin
        if (pick[3]) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          own_d   = pick[2:0];
          ptr_d   = pick[2:0];
        end
      end
      S_HOLD: begin
        if (cnt_q == LAST) state_d = S_OPEN;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      S_OPEN: begin
        if (!pick[3]) begin
          state_d = S_IDLE;
          own_d   = '0;
        end else if (pick[2:0] != own_q) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          own_d   = pick[2:0];
          ptr_d   = pick[2:0];
        end
      end
      default: begin
        state_d = S_IDLE;
        own_d   = '0;
      end
    endcase
  end

  // Value follows the next owner; a new winner always has req=1, so its
  // value loads on the grant edge. Owner req low in HOLD freezes it.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    grant_d = '0;
    own_req = 1'b0;
    own_val = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (busy_d && own_d == 3'(i)) grant_d[i] = 1'b1;
      if (own_d == 3'(i)) begin
        own_req = bus.req[i];
        own_val = bus.req_value[i*VAL_W +: VAL_W];
      end
    end
    disp_d = disp_q;
    ovf_d  = ovf_q;
    if (!busy_d) begin
      disp_d = IDLE_V;
      ovf_d  = 1'b0;
    end else if (own_req) begin
      ovf_d  = over(own_val);
      disp_d = ovf_d ? MAX_V : own_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= PTR_RST;
      own_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      disp_q  <= IDLE_V;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.owner_id   = own_q;
  assign bus.busy       = busy_q;
  assign bus.disp_value = disp_q;
  assign bus.overflow   = ovf_q;

endmodule
